// File: rtl/rtc_pkg.sv
// Shared limits and types for the hours/minutes/seconds core.
package rtc_pkg;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HOUR_MAX = 5'd23;
  localparam logic [4:0] HOUR_12  = 5'd12;

  // {tens, ones} BCD digit pair
  typedef logic [7:0] bcd_pair_t;

endpackage

// File: rtl/bin2bcd99.sv
// Binary 0-99 to packed BCD pair {tens, ones}; purely combinational.
module bin2bcd99
  import rtc_pkg::*;
(
  input  logic [6:0] bin,
  output bcd_pair_t  bcd
);

  logic [3:0] tens;
  logic [6:0] rem;

  // Repeated subtraction of ten; at most nine steps for inputs below 100.
  always_comb begin
    tens = '0;
    rem  = bin;
    for (int i = 0; i < 9; i++) begin
      if (rem >= 7'd10) begin
        rem  = rem - 7'd10;
        tens = tens + 4'd1;
      end
    end
    bcd = {tens, rem[3:0]};
  end

endmodule

// File: rtl/rtc_hms_core.sv
// Time-of-day core: single prescaler to a 1 s tick, sec/min/hour carry
// chain, validated load, 12/24 h display and sticky HH:MM alarm.
module rtc_hms_core
  import rtc_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int PRESC_W = 26
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic       run,
  input  logic       set_en,
  input  logic [4:0] set_hh,
  input  logic [5:0] set_mm,
  input  logic [5:0] set_ss,
  input  logic       mode12,
  input  logic       alarm_en,
  input  logic [4:0] alarm_hh,
  input  logic [5:0] alarm_mm,
  input  logic       alarm_ack,
  output logic [7:0] hh_bcd,
  output logic [7:0] mm_bcd,
  output logic [7:0] ss_bcd,
  output logic       pm,
  output logic       sec_tick,
  output logic       day_tick,
  output logic       set_err,
  output logic       alarm
);

  localparam logic [PRESC_W-1:0] PRESC_TOP = PRESC_W'(CLK_HZ - 1);

  logic [PRESC_W-1:0] presc;
  logic [5:0]         sec, min;
  logic [4:0]         hour;

  logic       due, set_ok, day_wrap, alarm_hit;
  logic       sec_w, min_w, hour_w;
  logic [5:0] nsec, nmin;
  logic [4:0] nhour, hr_disp;

  assign due    = run && (presc == PRESC_TOP);
  assign set_ok = set_en && (set_hh <= HOUR_MAX) && (set_mm <= MIN_MAX)
                         && (set_ss <= SEC_MAX);

  // Time one second ahead of the current state, plus the day-wrap flag.
  always_comb begin
    sec_w    = (sec == SEC_MAX);
    min_w    = (min == MIN_MAX);
    hour_w   = (hour == HOUR_MAX);
    nsec     = sec_w ? '0 : sec + 6'd1;
    nmin     = sec_w ? (min_w ? '0 : min + 6'd1) : min;
    nhour    = (sec_w && min_w) ? (hour_w ? '0 : hour + 5'd1) : hour;
    day_wrap = sec_w && min_w && hour_w;
    // nhour/nmin never exceed 23/59, so out-of-range alarm values cannot hit
    alarm_hit = alarm_en && (nsec == 6'd0) && (nhour == alarm_hh)
                         && (nmin == alarm_mm);
  end

  // Prescaler and time registers; a valid load beats a same-cycle advance.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      presc <= '0;
      sec   <= '0;
      min   <= '0;
      hour  <= '0;
    end else if (set_ok) begin
      presc <= '0;
      sec   <= set_ss;
      min   <= set_mm;
      hour  <= set_hh;
    end else if (run) begin
      presc <= due ? '0 : presc + 1'b1;
      if (due) begin
        sec  <= nsec;
        min  <= nmin;
        hour <= nhour;
      end
    end
  end

  // One-cycle status pulses.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      sec_tick <= 1'b0;
      day_tick <= 1'b0;
      set_err  <= 1'b0;
    end else begin
      sec_tick <= due && !set_ok;
      day_tick <= due && !set_ok && day_wrap;
      set_err  <= set_en && !set_ok;
    end
  end

  // Sticky alarm: setting on a matching advance wins over ack/disable.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn)                           alarm <= 1'b0;
    else if (due && !set_ok && alarm_hit)  alarm <= 1'b1;
    else if (alarm_ack || !alarm_en)       alarm <= 1'b0;
  end

  // 12 h mapping: 0 -> 12, 13..23 -> 1..11, others pass through.
  always_comb begin
    hr_disp = hour;
    if (mode12) begin
      if (hour == 5'd0)         hr_disp = HOUR_12;
      else if (hour > HOUR_12)  hr_disp = hour - HOUR_12;
    end
  end

  assign pm = mode12 && (hour >= HOUR_12);

  logic      [2:0][6:0] bin_val;
  bcd_pair_t [2:0]      bcd_val;

  assign bin_val[2] = {2'b00, hr_disp};
  assign bin_val[1] = {1'b0, min};
  assign bin_val[0] = {1'b0, sec};

  for (genvar g = 0; g < 3; g++) begin : g_bcd
    bin2bcd99 u_bcd (.bin(bin_val[g]), .bcd(bcd_val[g]));
  end

  assign hh_bcd = bcd_val[2];
  assign mm_bcd = bcd_val[1];
  assign ss_bcd = bcd_val[0];

endmodule

// File: tb/tb_rtc_hms_core.sv
// Directed bench for rtc_hms_core with a 4-cycle second.
module tb_rtc_hms_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run, set_en, mode12, alarm_en, alarm_ack;
  logic [4:0] set_hh, alarm_hh;
  logic [5:0] set_mm, set_ss, alarm_mm;
  logic [7:0] hh_bcd, mm_bcd, ss_bcd;
  logic       pm, sec_tick, day_tick, set_err, alarm;

  int n_vec = 0;
  int n_err = 0;

  rtc_hms_core #(.CLK_HZ(4), .PRESC_W(3)) dut (
    .CLOCK_50(clk), .Resetn(rst_n), .run(run), .set_en(set_en),
    .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss), .mode12(mode12),
    .alarm_en(alarm_en), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
    .alarm_ack(alarm_ack), .hh_bcd(hh_bcd), .mm_bcd(mm_bcd), .ss_bcd(ss_bcd),
    .pm(pm), .sec_tick(sec_tick), .day_tick(day_tick), .set_err(set_err),
    .alarm(alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // advance n rising edges, then settle 1 time unit past the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    set_hh = h; set_mm = m; set_ss = s; set_en = 1'b1;
    step(1);
    set_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; set_en = 1'b0; mode12 = 1'b1;
    alarm_en = 1'b0; alarm_ack = 1'b0;
    set_hh = '0; set_mm = '0; set_ss = '0; alarm_hh = '0; alarm_mm = '0;
    #2;
    // reset state, 12 h view of hour 0
    chk("rst_hh12", hh_bcd, 8'h12);
    chk("rst_pm", pm, 1'b0);
    mode12 = 1'b0; #1;
    chk("rst_time", {hh_bcd, mm_bcd, ss_bcd}, 24'h000000);
    chk("rst_pulses", {sec_tick, day_tick, set_err, alarm}, 4'b0000);

    @(posedge clk); #1;
    rst_n = 1'b1; run = 1'b1;
    // ticks at cycles 4, 8, 12
    step(3); chk("no_tick_c3", sec_tick, 1'b0);
    step(1); chk("tick_c4", {sec_tick, day_tick, ss_bcd}, {2'b10, 8'h01});
    step(1); chk("tick_pulse_end", sec_tick, 1'b0);
    step(3); chk("tick_c8", {sec_tick, ss_bcd}, {1'b1, 8'h02});
    step(4); chk("tick_c12", {sec_tick, day_tick, ss_bcd}, {2'b10, 8'h03});

    // load 23:59:58 and roll the day
    load(5'd23, 6'd59, 6'd58);
    chk("load_time", {hh_bcd, mm_bcd, ss_bcd, sec_tick}, {24'h235958, 1'b0});
    step(3); chk("load_no_early_tick", sec_tick, 1'b0);
    step(1); chk("t_235959", {hh_bcd, mm_bcd, ss_bcd, sec_tick, day_tick}, {24'h235959, 2'b10});
    step(4); chk("day_wrap", {hh_bcd, mm_bcd, ss_bcd, sec_tick, day_tick}, {24'h000000, 2'b11});
    step(1); chk("day_pulse_end", {sec_tick, day_tick}, 2'b00);

    // rejected load 24:00:00 at presc=1 keeps phase
    load(5'd24, 6'd0, 6'd0);
    chk("err_24h", {set_err, hh_bcd, mm_bcd, ss_bcd}, {1'b1, 24'h000000});
    step(1); chk("err_pulse_end", {set_err, sec_tick}, 2'b00);
    step(1); chk("err_phase_kept", {sec_tick, ss_bcd}, {1'b1, 8'h01});
    load(5'd10, 6'd60, 6'd0);
    chk("err_60m", {set_err, hh_bcd, mm_bcd, ss_bcd}, {1'b1, 24'h000001});
    step(1); chk("err60_pulse_end", set_err, 1'b0);

    // pause at presc=2 for 10 cycles
    run = 1'b0;
    step(10); chk("pause_hold", {sec_tick, ss_bcd}, {1'b0, 8'h01});
    run = 1'b1;
    step(1); chk("resume_c1", sec_tick, 1'b0);
    step(1); chk("resume_c2", {sec_tick, ss_bcd}, {1'b1, 8'h02});

    // 12/24 h display
    mode12 = 1'b1;
    load(5'd0, 6'd0, 6'd0);  chk("h12_0",  {hh_bcd, pm}, {8'h12, 1'b0});
    load(5'd11, 6'd0, 6'd0); chk("h12_11", {hh_bcd, pm}, {8'h11, 1'b0});
    load(5'd12, 6'd0, 6'd0); chk("h12_12", {hh_bcd, pm}, {8'h12, 1'b1});
    load(5'd13, 6'd0, 6'd0); chk("h12_13", {hh_bcd, pm}, {8'h01, 1'b1});
    mode12 = 1'b0; #1;       chk("h24_13", {hh_bcd, pm}, {8'h13, 1'b0});
    load(5'd0, 6'd0, 6'd0);  chk("h24_0",  {hh_bcd, pm}, {8'h00, 1'b0});

    // alarm 07:30
    alarm_hh = 5'd7; alarm_mm = 6'd30; alarm_en = 1'b1;
    load(5'd7, 6'd29, 6'd59); chk("alm_load", alarm, 1'b0);
    step(3); chk("alm_before", alarm, 1'b0);
    step(1); chk("alm_set", {alarm, hh_bcd, mm_bcd, ss_bcd}, {1'b1, 24'h073000});
    step(2); chk("alm_hold", alarm, 1'b1);
    alarm_ack = 1'b1;
    step(1); chk("alm_ack", alarm, 1'b0);
    alarm_ack = 1'b0;
    load(5'd7, 6'd29, 6'd59);
    step(3); alarm_ack = 1'b1;
    step(1); chk("alm_set_beats_ack", alarm, 1'b1);
    alarm_ack = 1'b0; alarm_en = 1'b0;
    step(1); chk("alm_en_clear", alarm, 1'b0);
    alarm_en = 1'b1;
    load(5'd7, 6'd30, 6'd0); chk("alm_load_no_set", alarm, 1'b0);
    step(1); chk("alm_load_no_set2", alarm, 1'b0);

    // reset mid-count
    step(2);
    rst_n = 1'b0; #1;
    chk("rst_mid", {hh_bcd, mm_bcd, ss_bcd, sec_tick, day_tick, set_err, alarm},
        {24'h000000, 4'b0000});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rtc_hms_core.md
# rtc_hms_core

Parametrised real-time-of-day core: divides the system clock to a 1 s tick and keeps hours/minutes/seconds, with run/pause, validated time load, a 12/24-hour display mode and a sticky HH:MM alarm. Outputs are packed BCD digit pairs ready for the board's seven-segment decoders; the block replaces hard-wired per-unit dividers with one prescaler and a carry chain.

## Interface
- `CLK_HZ`, 50000000, input clock cycles per second; legal range ≥ 2.
- `PRESC_W`, 26, prescaler width; 2^PRESC_W ≥ CLK_HZ.
- `CLOCK_50`  in  1  system clock, rising edge.
- `Resetn`  in  1  reset, asynchronous, active-low.
- `run`  in  1  1 = time advances, 0 = prescaler and time held.
- `set_en`  in  1  one-cycle load strobe.
- `set_hh` / `set_mm` / `set_ss`  in  5/6/6  binary load values.
- `mode12`  in  1  0 = 24 h display, 1 = 12 h display.
- `alarm_en`  in  1  arms alarm; 0 also clears `alarm`.
- `alarm_hh` / `alarm_mm`  in  5/6  binary alarm time (24 h).
- `alarm_ack`  in  1  clears `alarm`.
- `hh_bcd` / `mm_bcd` / `ss_bcd`  out  8 each  {tens, ones} BCD.
- `pm`  out  1  12 h mode and hour ≥ 12.
- `sec_tick`  out  1  one-cycle pulse on each second advance.
- `day_tick`  out  1  one-cycle pulse on 23:59:59 → 00:00:00.
- `set_err`  out  1  one-cycle pulse on rejected load.
- `alarm`  out  1  sticky alarm flag.

## Operation
- State: `presc` (PRESC_W), `sec` (6), `min` (6), `hour` (5), all binary, plus `alarm` and pulse registers.
- Reset: all state 0; outputs read 00:00:00, `pm`=0, all pulses 0, `alarm`=0 (12 h mode shows 12).
- Prescaler: when `run`=1, increments; at CLK_HZ−1 wraps to 0 and the time advances by one second. `run`=0 freezes `presc` and time; resuming continues from the frozen count.
- Carry chain: sec 59→0 carries to min; min 59→0 carries to hour; hour 23→0 with all carries asserts `day_tick`.
- Load (`set_en`=1): highest priority, overrides any same-cycle advance. If set_hh ≤ 23, set_mm ≤ 59 and set_ss ≤ 59: load all three, clear `presc` to 0, no `sec_tick`. Otherwise: time and `presc` unchanged (advance, if due, still occurs), `set_err` pulses.
- Display: `hh_bcd` = hour in 24 h mode; in 12 h mode 0→12, 1–11→1–11, 12→12, 13–23→1–11. `pm` = mode12 & (hour ≥ 12). BCD outputs are combinational from state registers.
- Alarm: on an advance whose new time has sec=0, hour=alarm_hh, min=alarm_mm and `alarm_en`=1, `alarm` sets. Clears on `alarm_ack`=1 or `alarm_en`=0. Set and clear in the same cycle: set wins. A load never triggers the alarm. Out-of-range alarm values never match.

## Timing
- Advance occurs on the edge where `presc`=CLK_HZ−1 and `run`=1; new time, `sec_tick` (and `day_tick`, `alarm` if applicable) are all visible after that same edge. `sec_tick` period exactly CLK_HZ cycles while running.
- Load takes effect on the edge sampling `set_en`; first following `sec_tick` exactly CLK_HZ cycles later (given `run`=1).
- `set_err` asserted for the single cycle after the rejecting edge.
- `mode12` change affects outputs combinationally, no state change.
- Reset asserted mid-count: immediate return to reset values, no pulses generated.

## Structure
- Shared package `rtc_pkg`: SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, 8-bit BCD-pair type, 12 h conversion constant 12.
- Sub-module `bin2bcd99`: combinational binary 0–99 → {tens, ones}; instantiated three times (hour-after-12h-mapping, min, sec).

## Test plan
- Reset, CLK_HZ=4, `run`=1: `sec_tick` at cycles 4, 8, 12; ss_bcd 01, 02, 03; `day_tick`=0.
- Load 23:59:58 then run 8 cycles: 23:59:59 then 00:00:00 with `day_tick` and `sec_tick` high together for one cycle.
- Load 24:00:00 (and separately 10:60:00): `set_err` one-cycle pulse, time unchanged, prescaler phase unchanged.
- `run`=0 for 10 cycles at presc=2: no tick; on resume, next tick after exactly 2 cycles.
- `mode12`=1 with hours 0, 11, 12, 13: hh_bcd 12/11/12/01, `pm` 0/0/1/1; `mode12`=0 shows 00/11/12/13, `pm`=0.
- Alarm 07:30, load 07:29:59, `alarm_en`=1: `alarm` sets with the 07:30:00 tick, holds until `alarm_ack`; ack coincident with a set edge leaves `alarm`=1; loading 07:30:00 directly does not set it.
